i2c_apb_master: RTL

- Upstream command sequencer for the I2C controller's APB slave port.
- Accepts a valid/ready command stream (register write, register read, masked poll) from a host-side agent, such as a boot ROM sequencer or DMA descriptor engine.
- Issues compliant two-phase APB transfers to the controller, applies a per-transfer ready timeout, and returns one response per command.

---
 rtl/i2c_apb_master.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_apb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_apb_master
// Description : Command sequencer that turns a valid/ready command stream
//               (write, read, masked poll) into two-phase APB transfers
//               towards the I2C controller, with a per-transfer ready
//               timeout and one response per command.
//               Optional macro I2C_APB_MASTER_POLL_EN enables op 10 (poll);
//               without it op 10 is rejected like the reserved op 11.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_apb_master #(
    parameter int TIMEOUT  = 256,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        apb_sel,
    output logic        apb_en,
    output logic        apb_write,
    output logic [31:0] apb_addr,
    output logic [31:0] apb_wdata,
    input  logic        apb_ready,
    input  logic [31:0] apb_rdata
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_op_write = 2'b00;
    localparam logic [1:0] c_op_read  = 2'b01;
    localparam logic [1:0] c_op_poll  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_GAP    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [31:0]        r_data;
    logic [WAIT_W-1:0]  r_wait;

    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;
    logic               r_sel;
    logic               r_en;
    logic               r_write;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

`ifdef I2C_APB_MASTER_POLL_EN
    localparam int ATT_W = $clog2(POLL_MAX) + 1;
    localparam int GAP_W = $clog2(POLL_GAP) + 1;
    localparam logic [ATT_W-1:0] c_att_last = ATT_W'(POLL_MAX - 1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

    logic [31:0]        r_mask;
    logic [ATT_W-1:0]   r_att;
    logic [GAP_W-1:0]   r_gap;
    logic               w_match;

    // Poll succeeds when every masked bit of the read data equals the compare value
    assign w_match = (((apb_rdata ^ r_data) & r_mask) == 32'd0);
`else
    logic               w_unused_mask;
    assign w_unused_mask = ^cmd_mask;
`endif

    logic w_op_apb;

    // Decide whether the offered opcode produces APB traffic or an immediate error
    always_comb begin
        w_op_apb = (cmd_op == c_op_write) || (cmd_op == c_op_read);
`ifdef I2C_APB_MASTER_POLL_EN
        if (cmd_op == c_op_poll) begin
            w_op_apb = 1'b1;
        end
`endif
    end

    // Sequencer: state, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_data      <= 32'd0;
            r_wait      <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_sel       <= 1'b0;
            r_en        <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
`ifdef I2C_APB_MASTER_POLL_EN
            r_mask      <= 32'd0;
            r_att       <= '0;
            r_gap       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_addr      <= cmd_addr;
                        r_data      <= cmd_data;
`ifdef I2C_APB_MASTER_POLL_EN
                        r_mask      <= cmd_mask;
                        r_att       <= '0;
`endif
                        if (w_op_apb) begin
                            r_state   <= S_SETUP;
                            r_sel     <= 1'b1;
                            r_en      <= 1'b0;
                            r_write   <= (cmd_op == c_op_write);
                            r_wdata   <= (cmd_op == c_op_write) ? cmd_data : 32'd0;
                        end else begin
                            // Reserved (or disabled) opcode: reject without touching APB
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'd0;
                        end
                    end
                end

                S_SETUP: begin
                    r_en    <= 1'b1;
                    r_wait  <= '0;
                    r_state <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (apb_ready) begin
                        r_sel <= 1'b0;
                        r_en  <= 1'b0;
                        case (r_op)
                            c_op_write: begin
                                r_state     <= S_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b0;
                                r_rsp_data  <= 32'd0;
                            end
                            c_op_read: begin
                                r_state     <= S_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b0;
                                r_rsp_data  <= apb_rdata;
                            end
`ifdef I2C_APB_MASTER_POLL_EN
                            c_op_poll: begin
                                if (w_match) begin
                                    r_state     <= S_RESP;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b0;
                                    r_rsp_data  <= apb_rdata;
                                end else if (r_att == c_att_last) begin
                                    // Final allowed attempt missed: report last value seen
                                    r_state     <= S_RESP;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                    r_rsp_data  <= apb_rdata;
                                end else begin
                                    r_att <= r_att + 1'b1;
                                    if (POLL_GAP == 0) begin
                                        // No idle spacing: back-to-back SETUP, sel stays high
                                        r_state <= S_SETUP;
                                        r_sel   <= 1'b1;
                                        r_en    <= 1'b0;
                                    end else begin
                                        r_state <= S_GAP;
                                        r_gap   <= '0;
                                    end
                                end
                            end
`endif
                            default: begin
                                r_state     <= S_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                                r_rsp_data  <= 32'd0;
                            end
                        endcase
                    end else if (r_wait == c_wait_last) begin
                        // Slave never answered: abandon the transfer and the command
                        r_sel       <= 1'b0;
                        r_en        <= 1'b0;
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= 32'd0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

`ifdef I2C_APB_MASTER_POLL_EN
                S_GAP: begin
                    if (r_gap == c_gap_last) begin
                        r_state <= S_SETUP;
                        r_sel   <= 1'b1;
                        r_en    <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
`endif

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= 32'd0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_sel       <= 1'b0;
                    r_en        <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign apb_sel   = r_sel;
    assign apb_en    = r_en;
    assign apb_write = r_write;
    assign apb_addr  = r_addr;
    assign apb_wdata = r_wdata;

endmodule
`default_nettype wire
